// File: rtl/noc_traffic_pe_if.sv
// Flit and credit links between a traffic PE and its NoC port pair.
// The master side is the PE: it drives injected flits and returned credits.
interface noc_traffic_pe_if #(
    parameter int FLIT_W = 39,
    parameter int CRD_W  = 2
);
    logic [FLIT_W-1:0] flit_out;
    logic [FLIT_W-1:0] flit_in;
    logic [CRD_W-1:0]  credit_in;
    logic [CRD_W-1:0]  credit_out;

    modport master (
        output flit_out,
        output credit_out,
        input  flit_in,
        input  credit_in
    );

    modport slave (
        input  flit_out,
        input  credit_out,
        output flit_in,
        output credit_in
    );
endinterface

// File: rtl/noc_traffic_pe.sv
// Credit-aware traffic generator / sink for one NoC user port pair.
// Sends PKT_LEN-flit packets round-robin over VCs, gated by per-VC credits,
// and sinks every received flit, returning one credit per flit.
module noc_traffic_pe #(
    parameter int NUM_VCS         = 2,
    parameter int NUM_RECV_PORTS  = 16,
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int BUF_DEPTH       = 4,
    parameter int PKT_LEN         = 4,
    parameter int INJ_PERIOD      = 10,
    parameter int NUM_PKTS        = 13,
    localparam int VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int DEST_W = $clog2(NUM_RECV_PORTS),
    localparam int CNT_W  = $clog2(BUF_DEPTH + 1),
    localparam int FLIT_W = 2 + FLIT_DATA_WIDTH + DEST_W + VC_W,
    localparam int IDX_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1,
    localparam int GAP_W  = (INJ_PERIOD > 0) ? $clog2(INJ_PERIOD + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DEST_W-1:0] cfg_dest,
    noc_traffic_pe_if.master  net,
    output logic [15:0]       pkts_sent,
    output logic [15:0]       flits_rcvd,
    output logic [15:0]       pkts_rcvd,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} state_t;

    state_t                     state_q, state_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [IDX_W-1:0]           idx_q;
    logic [VC_W-1:0]            cur_vc_q;
    logic [DEST_W-1:0]          dest_q, dest_sel;
    logic [FLIT_DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]           credit_q [NUM_VCS];
    logic [NUM_VCS-1:0]         inc_v, dec_v;
    logic                       send, last, has_credit;
    logic                       crd_vld;
    logic [VC_W-1:0]            crd_vc;
    logic                       rx_vld, rx_tail;
    logic [VC_W-1:0]            rx_vc;
    logic                       rx_unused;

    assign crd_vld    = net.credit_in[VC_W];
    assign crd_vc     = net.credit_in[VC_W-1:0];
    assign rx_vld     = net.flit_in[FLIT_W-1];
    assign rx_tail    = net.flit_in[FLIT_W-2];
    assign rx_vc      = net.flit_in[FLIT_DATA_WIDTH +: VC_W];
    // Destination and payload of received flits are not needed by the sink.
    assign rx_unused  = ^{net.flit_in[FLIT_W-3 -: DEST_W], net.flit_in[FLIT_DATA_WIDTH-1:0]};

    assign last       = (idx_q == IDX_W'(PKT_LEN - 1));
    assign dest_sel   = (idx_q == '0) ? cfg_dest : dest_q;
    assign has_credit = (credit_q[cur_vc_q] != '0);

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // TX next state, gap countdown and send decision; en=0 freezes everything.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        send    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (INJ_PERIOD == 0) begin
                        state_d = SEND;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(INJ_PERIOD);
                    end
                end
            end
            GAP: begin
                if (en) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q <= GAP_W'(1)) state_d = SEND;
                end
            end
            SEND: begin
                if (en && has_credit) begin
                    send = 1'b1;
                    if (last) begin
                        if ((NUM_PKTS != 0) && (pkts_sent == 16'(NUM_PKTS - 1))) begin
                            state_d = DONE;
                        end else if (INJ_PERIOD != 0) begin
                            state_d = GAP;
                            gap_d   = GAP_W'(INJ_PERIOD);
                        end
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Flit emission, packet bookkeeping and round-robin VC selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net.flit_out <= '0;
            gap_q        <= '0;
            idx_q        <= '0;
            cur_vc_q     <= '0;
            dest_q       <= '0;
            data_q       <= '0;
            pkts_sent    <= '0;
            done         <= 1'b0;
        end else begin
            gap_q <= gap_d;
            done  <= (state_d == DONE);
            if (send) begin
                net.flit_out <= {1'b1, last, dest_sel, cur_vc_q, data_q};
                data_q       <= data_q + FLIT_DATA_WIDTH'(1);
                dest_q       <= dest_sel;
                if (last) begin
                    idx_q     <= '0;
                    pkts_sent <= pkts_sent + 16'd1;
                    cur_vc_q  <= (cur_vc_q == VC_W'(NUM_VCS - 1)) ? '0 : cur_vc_q + VC_W'(1);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else begin
                net.flit_out <= '0;
            end
        end
    end

    // Per-VC credit events for this cycle.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            inc_v[v] = crd_vld && (crd_vc == VC_W'(v));
            dec_v[v] = send && (cur_vc_q == VC_W'(v));
        end
    end

    // Credit counters; a return into a full counter saturates and flags err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CNT_W'(BUF_DEPTH);
            err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (inc_v[v] && !dec_v[v]) begin
                    if (credit_q[v] == CNT_W'(BUF_DEPTH)) err <= 1'b1;
                    else credit_q[v] <= credit_q[v] + CNT_W'(1);
                end else if (dec_v[v] && !inc_v[v]) begin
                    credit_q[v] <= credit_q[v] - CNT_W'(1);
                end
            end
        end
    end

    // Receive sink: one credit back per valid flit, plus flit/packet counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net.credit_out <= '0;
            flits_rcvd     <= '0;
            pkts_rcvd      <= '0;
        end else begin
            net.credit_out <= rx_vld ? {1'b1, rx_vc} : '0;
            if (rx_vld) begin
                flits_rcvd <= flits_rcvd + 16'd1;
                if (rx_tail) pkts_rcvd <= pkts_rcvd + 16'd1;
            end
        end
    end
endmodule

// File: doc/noc_traffic_pe.md
Name: noc_traffic_pe

Overview:
- Parametrised, credit-aware traffic-generating processing element that attaches to one user send/receive port pair of the NoC.
- Injects multi-flit packets (head/body/tail) to a programmable destination, round-robin across virtual channels, gated by per-VC credit counters.
- Sinks every incoming flit, returns one credit per received flit, and exposes counters and status for the testbench.

Parameters:
- NUM_VCS, 2: number of virtual channels; VC_W = (NUM_VCS>1) ? clog2(NUM_VCS) : 1.
- NUM_RECV_PORTS, 16: number of network endpoints; DEST_W = clog2(NUM_RECV_PORTS).
- FLIT_DATA_WIDTH, 32: flit payload width.
- BUF_DEPTH, 4: downstream flit buffer depth per VC, i.e. the initial credit count; CNT_W = clog2(BUF_DEPTH+1).
- PKT_LEN, 4: flits per packet, >=1. A value of 1 produces single-flit packets with tail=1.
- INJ_PERIOD, 10: idle cycles between a tail flit and the next head flit; 0 means back-to-back.
- NUM_PKTS, 13: packets to send before done; 0 means unlimited.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: injection enable.
- cfg_dest, input, DEST_W: destination endpoint, sampled at each head flit.
- flit_out, output, FLIT_W: {valid, tail, dest, vc, data}, MSB first; FLIT_W = 2+FLIT_DATA_WIDTH+DEST_W+VC_W.
- credit_in, input, 1+VC_W: {valid, vc}, credit returned from the network.
- flit_in, input, FLIT_W: received flit, same format as flit_out.
- credit_out, output, 1+VC_W: {valid, vc}, credit returned for a received flit.
- pkts_sent, output, 16: completed packets (tail flits sent).
- flits_rcvd, output, 16: valid flits received.
- pkts_rcvd, output, 16: received flits with tail=1.
- done, output, 1: NUM_PKTS packets sent.
- err, output, 1: sticky credit-overflow error.

Behaviour:
- Reset (asynchronous, any state):
  - flit_out=0, credit_out=0, all counters=0, done=0, err=0.
  - Every credit counter = BUF_DEPTH, cur_vc=0, state=IDLE.
  - Reset mid-packet abandons the packet; no tail is emitted.
- All outputs are registered. Receive and credit-return paths operate regardless of en.
- TX state machine:
  - IDLE: on en=1 go to GAP with gap_cnt = INJ_PERIOD, or directly to SEND if INJ_PERIOD=0.
  - GAP: decrement gap_cnt each cycle; on reaching 0 go to SEND.
  - SEND: emit one flit per cycle when credit[cur_vc] > 0, otherwise stall.
    - A stall drives flit_out=0 and keeps flit_idx unchanged.
    - Flit fields: vc=cur_vc; dest latched from cfg_dest at flit_idx=0 and held for the whole packet; data = (pkt_seq*PKT_LEN + flit_idx) mod 2^FLIT_DATA_WIDTH; tail = (flit_idx == PKT_LEN-1).
    - On tail: pkts_sent++, cur_vc = (cur_vc+1) mod NUM_VCS, flit_idx=0. Go to DONE if NUM_PKTS != 0 and pkts_sent reaches NUM_PKTS; otherwise go to GAP with INJ_PERIOD reloaded (or stay in SEND if INJ_PERIOD=0).
  - DONE: done=1, no further injection until reset.
  - en=0 in GAP or SEND freezes state, gap_cnt, flit_idx and the packet; flit_out=0. The packet resumes on the same flit when en returns.
- Credits:
  - A sent flit decrements credit[vc].
  - credit_in.valid increments credit[credit_in.vc].
  - A send and a returned credit on the same VC in the same cycle leave the count unchanged.
  - An increment at BUF_DEPTH (with no simultaneous send on that VC) sets err=1 and saturates the count.
  - The send decision uses the count before this cycle's return.
- RX path:
  - flit_in.valid=1 -> next cycle credit_out = {1, flit_in.vc} and flits_rcvd++.
  - If tail=1 also pkts_rcvd++.
  - flit_in.valid=0 -> credit_out=0 next cycle.
  - All counters wrap at 2^16.

Test Plan:
- Reset, then en=1, cfg_dest=10, PKT_LEN=4, INJ_PERIOD=10, credits returned 1 cycle after each flit -> first head at cycle 11 after en with data 0, vc 0, dest 10; tail at data 3; next head 10 idle cycles later on vc 1 with data 4.
- No credit_in, BUF_DEPTH=4, PKT_LEN=4, INJ_PERIOD=0 -> 4 flits on vc0 then vc1 packet sent; flit_out stays 0 afterwards; a single credit on vc0 releases exactly one flit.
- NUM_PKTS=3 with full credit return -> pkts_sent=3, done=1, no further valid flit_out over the next 100 cycles.
- Drive flit_in valid with vc=1, tail=1 -> credit_out={1,1} one cycle later, flits_rcvd=1, pkts_rcvd=1; a valid flit_in in the same cycle as a send is still credited.
- Extra credit_in on vc0 while credit[vc0]=BUF_DEPTH -> err=1 and stays set; count remains 4.
- Deassert en mid-packet after flit_idx=1 for 5 cycles -> no valid flits during the pause; flit_idx=2 is emitted first on resume; assert rst_n=0 mid-packet -> all outputs 0 immediately.
